// File: rtl/rf_dump_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rf_dump_reader
//
// Debug reader for the CPU register file. A start pulse walks a register
// address range (wrapping modulo 2**ADDR_W) through one asynchronous read
// port. Each word is snapshotted in its own LOAD cycle and streamed MSB-first
// as bytes over a valid/ready byte interface that feeds the UART transmitter.
// The core's write port is never stalled. Words are snapshotted one register
// at a time, so a core write lands in the dump only if it precedes that
// register's LOAD edge.
//
// Parameters
//   ADDR_W    register index width (32 registers by default)
//   DATA_W    register word width, a multiple of 8, sent as DATA_W/8 bytes
//   SEND_ADDR when 1, each word is preceded by a header byte holding its index
//
// Ports (all outputs are registered)
//   clk         rising-edge clock
//   RST_N       asynchronous active-low reset
//   DUMP_START  start request, honoured only in IDLE
//   DUMP_FIRST  first register index, latched on an accepted start
//   DUMP_LAST   last register index, latched on an accepted start
//   RF_ADR      read address to the register file read port
//   RF_RS       combinational read data for RF_ADR
//   TX_DATA     byte to the transmitter
//   TX_VALID    TX_DATA is valid; data and valid hold until accepted
//   TX_READY    transmitter accepts the byte on this edge
//   DUMP_BUSY   high from the accepted start until completion
//   DUMP_DONE   one-cycle completion pulse
// -----------------------------------------------------------------------------
module rf_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit SEND_ADDR = 1'b1
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              DUMP_START,
  input  logic [ADDR_W-1:0] DUMP_FIRST,
  input  logic [ADDR_W-1:0] DUMP_LAST,
  output logic [ADDR_W-1:0] RF_ADR,
  input  logic [DATA_W-1:0] RF_RS,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              DUMP_BUSY,
  output logic              DUMP_DONE
);

  // Bytes emitted per register: the word bytes plus the optional header.
  localparam int NBYTES = DATA_W / 8;
  localparam int NXFER  = NBYTES + (SEND_ADDR ? 1 : 0);
  localparam int CNT_W  = $clog2(NXFER + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NXFER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  // Registered state and datapath.
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;      // register currently being dumped
  logic [ADDR_W-1:0]   r_last;      // latched last index
  logic [DATA_W-1:0]   r_shift;     // remaining word bytes, next byte at the top
  logic [CNT_W-1:0]    r_cnt;       // bytes left for this register, incl. TX_DATA
  logic                r_settle;    // first LOAD of a dump waits one extra cycle
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_done;

  // Next-state values.
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   w_last_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_settle_nxt;
  logic [7:0]          w_tx_data_nxt;
  logic                w_tx_valid_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  logic                w_xfer;
  logic                w_last_byte;
  logic                w_last_reg;
  logic [7:0]          w_header;

  assign w_xfer      = r_tx_valid && TX_READY;
  assign w_last_byte = (r_cnt == CNT_ONE);
  assign w_last_reg  = (r_addr == r_last);
  assign w_header    = 8'(r_addr);

  // ---------------------------------------------------------------------------
  // State and output registers.
  // NOTE: non-blocking assignments here so every flop samples the values that
  // existed before the edge; blocking ones would make results order-dependent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_last     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_settle   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_last     <= w_last_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_settle   <= w_settle_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: the default assignment first guarantees every path assigns the
  // variable, so no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (DUMP_START) w_state_nxt = S_LOAD;
      // The first register of a dump gives the read port a full cycle after
      // RF_ADR leaves its idle value before the word is captured.
      S_LOAD: if (!r_settle) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_xfer && w_last_byte) begin
          w_state_nxt = w_last_reg ? S_DONE : S_LOAD;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_addr_nxt     = r_addr;
    w_last_nxt     = r_last;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_settle_nxt   = r_settle;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (DUMP_START) begin
          w_addr_nxt   = DUMP_FIRST;
          w_last_nxt   = DUMP_LAST;
          w_busy_nxt   = 1'b1;
          w_settle_nxt = 1'b1;
        end
      end

      S_LOAD: begin
        if (r_settle) begin
          w_settle_nxt = 1'b0;
        end else begin
          // Snapshot this register now; later core writes are not seen.
          if (SEND_ADDR) begin
            w_tx_data_nxt = w_header;
            w_shift_nxt   = RF_RS;
          end else begin
            w_tx_data_nxt = RF_RS[DATA_W-1 -: 8];
            w_shift_nxt   = RF_RS << 8;
          end
          w_cnt_nxt      = CNT_LOAD;
          w_tx_valid_nxt = 1'b1;
        end
      end

      S_SEND: begin
        if (w_xfer) begin
          if (w_last_byte) begin
            // Drop valid for one cycle; either finish or reload the next index.
            w_tx_valid_nxt = 1'b0;
            w_cnt_nxt      = '0;
            if (w_last_reg) begin
              w_busy_nxt = 1'b0;
              w_done_nxt = 1'b1;
            end else begin
              w_addr_nxt = r_addr + ADDR_W'(1);
            end
          end else begin
            w_tx_data_nxt = r_shift[DATA_W-1 -: 8];
            w_shift_nxt   = r_shift << 8;
            w_cnt_nxt     = r_cnt - CNT_ONE;
          end
        end
      end

      S_DONE: begin
        w_done_nxt = 1'b0;
      end

      default: begin
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  assign RF_ADR    = r_addr;
  assign TX_DATA   = r_tx_data;
  assign TX_VALID  = r_tx_valid;
  assign DUMP_BUSY = r_busy;
  assign DUMP_DONE = r_done;

endmodule

// File: tb/tb_rf_dump_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rf_dump_reader
//
// Two reader instances share one register-file model: u_dut_a sends a header
// byte per word, u_dut_b does not. Stimulus pushes the expected byte stream
// into a scoreboard queue; an independent monitor pops and compares on every
// accepted byte and checks that a stalled byte holds steady.
// -----------------------------------------------------------------------------
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [4:0]  first;
  logic [4:0]  last;
  logic        tx_ready;

  logic [31:0] rf_mem [32];

  logic [4:0]  a_adr, b_adr;
  logic [31:0] a_rs, b_rs;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_busy, b_busy;
  logic        a_done, b_done;

  always #5 clk = ~clk;

  assign a_rs = rf_mem[a_adr];
  assign b_rs = rf_mem[b_adr];

  rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .SEND_ADDR(1'b1)) u_dut_a (
    .clk        (clk),
    .RST_N      (rst_n),
    .DUMP_START (start_a),
    .DUMP_FIRST (first),
    .DUMP_LAST  (last),
    .RF_ADR     (a_adr),
    .RF_RS      (a_rs),
    .TX_DATA    (a_data),
    .TX_VALID   (a_valid),
    .TX_READY   (tx_ready),
    .DUMP_BUSY  (a_busy),
    .DUMP_DONE  (a_done)
  );

  rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .SEND_ADDR(1'b0)) u_dut_b (
    .clk        (clk),
    .RST_N      (rst_n),
    .DUMP_START (start_b),
    .DUMP_FIRST (first),
    .DUMP_LAST  (last),
    .RF_ADR     (b_adr),
    .RF_RS      (b_rs),
    .TX_DATA    (b_data),
    .TX_VALID   (b_valid),
    .TX_READY   (tx_ready),
    .DUMP_BUSY  (b_busy),
    .DUMP_DONE  (b_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       sel;   // 0: u_dut_a, 1: u_dut_b
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q [$];
  int          xfer_cnt   [2] = '{0, 0};
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [7:0]  prev_data  [2] = '{8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic sel, input logic [7:0] d);
    exp_t e;
    e.sel  = sel;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Expected bytes for one register; u_dut_a adds the index header.
  task automatic push_reg(input logic sel, input logic [4:0] adr, input logic [31:0] w);
    if (!sel) push_byte(sel, {3'b000, adr});
    push_byte(sel, w[31:24]);
    push_byte(sel, w[23:16]);
    push_byte(sel, w[15:8]);
    push_byte(sel, w[7:0]);
  endtask

  task automatic mon_port(input logic sel, input logic valid, input logic ready,
                          input logic [7:0] data);
    exp_t e;
    if (prev_stall[sel]) begin
      check("stall_hold_valid", 32'(valid), 32'd1);
      check("stall_hold_data", 32'(data), 32'(prev_data[sel]));
    end
    if (valid && ready) begin
      xfer_cnt[sel]++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_byte: dut %0d sent 0x%0h, expected nothing", sel, data);
      end else begin
        e = exp_q.pop_front();
        if (e.sel !== sel || e.data !== data) begin
          n_errors++;
          $display("FAIL byte_data: dut %0d sent 0x%0h, expected dut %0d byte 0x%0h",
                   sel, data, e.sel, e.data);
        end
      end
    end
    prev_stall[sel] = valid && !ready;
    prev_data[sel]  = data;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
      end else begin
        mon_port(1'b0, a_valid, tx_ready, a_data);
        mon_port(1'b1, b_valid, tx_ready, b_data);
      end
    end
  end

  // Runs one dump from just after a rising edge. k counts rising edges after
  // the edge that samples the start; observations are taken on falling edges.
  task automatic run_dump(input logic sel, input logic [4:0] f, input logic [4:0] l,
                          input bit rnd_ready, input bit poke, input int wr_idx,
                          input logic [31:0] wr_val,
                          output int busy_n, output int done_n, output int valid_lat,
                          output int last_xfer_k, output int done_k, output int busy_after);
    int   k;
    bit   done_seen;
    logic v, b, d;
    busy_n = 0; done_n = 0; valid_lat = -1; last_xfer_k = -1; done_k = -1;
    busy_after = 0; done_seen = 1'b0;
    first    = f;
    last     = l;
    tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    k = 0;
    while (1) begin
      @(negedge clk);
      v = sel ? b_valid : a_valid;
      b = sel ? b_busy  : a_busy;
      d = sel ? b_done  : a_done;
      if (b) begin
        if (done_seen) busy_after++;
        else busy_n++;
      end
      if (d) begin
        done_n++;
        if (!done_seen) begin
          done_k = k;
          // A start during the DONE cycle must be ignored.
          if (poke) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
          end
        end
        done_seen = 1'b1;
      end
      if (v && valid_lat < 0) begin
        valid_lat = k;
        // Core write right after this register's capture edge.
        if (wr_idx >= 0) rf_mem[5'(wr_idx)] = wr_val;
      end
      if (v && tx_ready) last_xfer_k = k;
      if (poke && k == 10) begin
        first = 5'd0;
        last  = 5'd0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a  = 1'b0; start_b = 1'b0;
      first    = f;
      last     = l;
      tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      k++;
      if (done_seen && k >= done_k + 4) break;
      if (k >= 3000) begin
        n_checks++;
        n_errors++;
        $display("FAIL dump_timeout: no DUMP_DONE after %0d cycles, expected one", k);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, valid_lat, last_k, done_k, busy_after, x0, w;

    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    first    = 5'd0;
    last     = 5'd0;
    tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[5'(i)] = 32'h0101_0101 * i + 32'h1000_0000;
    rf_mem[0]  = 32'h0000_0000;
    rf_mem[1]  = 32'h0000_0ABC;
    rf_mem[2]  = 32'hA1B2_C3D4;
    rf_mem[5]  = 32'hDEAD_BEEF;
    rf_mem[7]  = 32'h1234_5678;
    rf_mem[30] = 32'h1122_3344;
    rf_mem[31] = 32'h5566_7788;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_adr",  32'(a_adr),   32'd0);
    check("reset_tx_data", 32'(a_data),  32'd0);
    check("reset_valid",   32'(a_valid), 32'd0);
    check("reset_busy",    32'(a_busy),  32'd0);
    check("reset_done",    32'(a_done),  32'd0);
    check("reset_b_all",   32'({b_adr, b_data, b_valid, b_busy, b_done}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single register with header, ready always high.
    push_byte(1'b0, 8'h05); push_byte(1'b0, 8'hDE); push_byte(1'b0, 8'hAD);
    push_byte(1'b0, 8'hBE); push_byte(1'b0, 8'hEF);
    x0 = xfer_cnt[0];
    run_dump(1'b0, 5'd5, 5'd5, 1'b0, 1'b0, -1, 32'h0,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t1_valid_latency", 32'(valid_lat), 32'd2);
    check("t1_last_byte_edge", 32'(last_k), 32'd6);
    check("t1_busy_cycles", 32'(busy_n), 32'd7);
    check("t1_done_pulses", 32'(done_n), 32'd1);
    check("t1_done_after_last", 32'(done_k), 32'd7);
    check("t1_byte_count", 32'(xfer_cnt[0] - x0), 32'd5);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Wrapping range, no header.
    push_byte(1'b1, 8'h11); push_byte(1'b1, 8'h22); push_byte(1'b1, 8'h33); push_byte(1'b1, 8'h44);
    push_byte(1'b1, 8'h55); push_byte(1'b1, 8'h66); push_byte(1'b1, 8'h77); push_byte(1'b1, 8'h88);
    push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h00); push_byte(1'b1, 8'h0A); push_byte(1'b1, 8'hBC);
    x0 = xfer_cnt[1];
    run_dump(1'b1, 5'd30, 5'd1, 1'b0, 1'b0, -1, 32'h0,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t2_byte_count", 32'(xfer_cnt[1] - x0), 32'd16);
    check("t2_last_byte_edge", 32'(last_k), 32'd20);
    check("t2_done_pulses", 32'(done_n), 32'd1);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full file, random backpressure, starts poked mid-dump and in DONE.
    for (int a = 0; a < 32; a++) push_reg(1'b0, 5'(a), rf_mem[5'(a)]);
    x0 = xfer_cnt[0];
    run_dump(1'b0, 5'd0, 5'd31, 1'b1, 1'b1, -1, 32'h0,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t3_byte_count", 32'(xfer_cnt[0] - x0), 32'd160);
    check("t3_done_pulses", 32'(done_n), 32'd1);
    check("t3_busy_after_done", 32'(busy_after), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while x2's third byte is stalled.
    push_reg(1'b0, 5'd2, 32'hA1B2_C3D4);
    first = 5'd2; last = 5'd2; tx_ready = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    w = 0;
    while (!a_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("t4_valid_seen", 32'(a_valid), 32'd1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("t4_third_byte_held", 32'(a_data), 32'hB2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(a_valid), 32'd0);
    check("t4_rst_busy", 32'(a_busy), 32'd0);
    check("t4_rst_rf_adr", 32'(a_adr), 32'd0);
    check("t4_bytes_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_reg(1'b0, 5'd2, 32'hA1B2_C3D4);
    x0 = xfer_cnt[0];
    run_dump(1'b0, 5'd2, 5'd2, 1'b0, 1'b0, -1, 32'h0,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t4_clean_count", 32'(xfer_cnt[0] - x0), 32'd5);
    check("t4_clean_done", 32'(done_n), 32'd1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Core write just after x7's capture edge: old value now, new value next.
    push_reg(1'b0, 5'd7, 32'h1234_5678);
    run_dump(1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 7, 32'hCAFE_F00D,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t5_old_value_queue", 32'(exp_q.size()), 32'd0);
    push_reg(1'b0, 5'd7, 32'hCAFE_F00D);
    run_dump(1'b0, 5'd7, 5'd7, 1'b0, 1'b0, -1, 32'h0,
             busy_n, done_n, valid_lat, last_k, done_k, busy_after);
    check("t5_new_value_queue", 32'(exp_q.size()), 32'd0);
    check("t5_done_pulses", 32'(done_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
Debug reader for the CPU register file. On a start pulse it walks a register address range through one asynchronous read port, snapshots each 32-bit word, and streams it out as bytes over a valid/ready byte interface. The byte stream feeds the UART transmitter. Allows host-side inspection of x0..x31 without stalling the core's write port.

Parameters:
ADDR_W, 5, register address width (32 registers).
DATA_W, 32, register word width; fixed multiple of 8, emitted as DATA_W/8 bytes.
SEND_ADDR, 1, when 1 each word is preceded by a header byte {3'b000, addr}.

Ports:
clk  in  1  rising-edge system clock.
RST_N  in  1  asynchronous active-low reset.
DUMP_START  in  1  request, sampled only in IDLE.
DUMP_FIRST  in  ADDR_W  first register index, latched on accepted start.
DUMP_LAST  in  ADDR_W  last register index, latched on accepted start.
RF_ADR  out  ADDR_W  read address to the register file read port.
RF_RS  in  DATA_W  combinational read data for RF_ADR.
TX_DATA  out  8  byte to transmitter.
TX_VALID  out  1  TX_DATA valid.
TX_READY  in  1  transmitter accepts the byte on this edge.
DUMP_BUSY  out  1  high from accepted start until completion.
DUMP_DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RST_N=0): state IDLE; RF_ADR=0, TX_DATA=0, TX_VALID=0, DUMP_BUSY=0, DUMP_DONE=0; internal address, last-index, shift register and byte counter cleared. Takes effect immediately, even mid-transfer. An un-accepted byte is dropped.
- All outputs are registered.
- States: IDLE, LOAD, SEND, DONE.
- IDLE: on an edge with DUMP_START=1, latch FIRST/LAST, set addr=FIRST, RF_ADR=FIRST, DUMP_BUSY=1, go to LOAD. DUMP_START in any other state is ignored.
- LOAD (one cycle): at the edge, capture RF_RS into the shift register; word snapshot is per register, not whole-file.
  - Load the first byte: the header if SEND_ADDR=1, otherwise word[31:24].
  - Set TX_VALID=1, byte counter to the byte count, go to SEND.
  - First TX_VALID rises on the 2nd rising edge after the edge sampling DUMP_START.
- SEND: a byte transfers on an edge with TX_VALID&&TX_READY. TX_DATA and TX_VALID hold stable until that transfer; TX_READY may arrive in the same cycle TX_VALID rises.
  - On each transfer, present the next byte on the following cycle with TX_VALID kept high.
  - Word bytes are sent MSB first: [31:24],[23:16],[15:8],[7:0].
  - Bytes per register are 5 with SEND_ADDR=1, 4 with SEND_ADDR=0.
- After the final byte of a register transfers:
  - If addr==LAST: TX_VALID=0, go to DONE.
  - Otherwise: addr=(addr+1) mod 32, RF_ADR updated, TX_VALID=0, go to LOAD. This leaves exactly one TX_VALID-low cycle between registers.
- DONE: DUMP_DONE=1 and DUMP_BUSY=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Range rules:
  - FIRST==LAST dumps one register.
  - FIRST>LAST wraps 31->0, e.g. FIRST=30, LAST=1 dumps 30,31,0,1.
  - FIRST=0, LAST=31 dumps all 32.
  - x0 is dumped like any other register and reads 0.
- Concurrent core writes: a write landing before a register's LOAD edge is reflected in the dump; a write landing after it is not.
- TX_READY held low indefinitely: stall in SEND with no timeout.

Test Plan:
- Bench RF model with x5=0xDEADBEEF, SEND_ADDR=1, FIRST=LAST=5, TX_READY=1 -> bytes 0x05,0xDE,0xAD,0xBE,0xEF on 5 consecutive edges; DUMP_DONE pulses once, 1 cycle after the last byte; BUSY is high 7 cycles total.
- FIRST=30, LAST=1, x30=0x11223344, x31=0x55667788, x1=0x00000ABC, SEND_ADDR=0 -> 16 bytes in address order 30,31,0,1: 11 22 33 44 55 66 77 88 00 00 00 00 00 00 0A BC.
- TX_READY randomly low ~50% during a full 0..31 dump -> every byte transferred exactly once, TX_DATA never changes while VALID&&!READY, 160 bytes total, header 0x1F precedes x31's word.
- DUMP_START pulsed again mid-dump and in the DONE cycle -> ignored; exactly one DUMP_DONE pulse; byte count unchanged.
- RST_N low while waiting for x2's third byte -> TX_VALID, DUMP_BUSY, RF_ADR go to 0 asynchronously before the next edge; a following start with FIRST=LAST=2 produces a clean 5-byte dump.
- Core write x7<=0xCAFEF00D on the LOAD edge+1 for x7 -> dumped x7 shows the old value; a repeat dump shows 0xCAFEF00D.
